// File: rtl/minesweeper_pkg.sv
// Shared cell layout, board geometry and FSM encoding
// for the minesweeper board generator and its neighbours.
package minesweeper_pkg;

    localparam int CELL_W    = 7;
    localparam int BOARD_DIM = 16;
    localparam int CELL_MINE = 0;
    localparam int CELL_REV  = 1;
    localparam int CELL_FLAG = 2;

    typedef logic [0:CELL_W-1] cell_t;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CLEAR     = 3'd1;
    localparam logic [2:0] S_PLACE_RD  = 3'd2;
    localparam logic [2:0] S_PLACE_CHK = 3'd3;
    localparam logic [2:0] S_COUNT     = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic cell_t make_cell(input logic mine,
                                        input logic [3:0] cnt);
        cell_t c;
        c            = '0;
        c[CELL_MINE] = mine;
        c[CELL_REV]  = 1'b0;
        c[CELL_FLAG] = 1'b0;
        c[3:6]       = cnt;
        return c;
    endfunction

endpackage

// File: rtl/minesweeper_board_gen_if.sv
// Control and RAM-port bundle between the board generator
// (master) and game control plus board RAM (slave).
interface minesweeper_board_gen_if;
    import minesweeper_pkg::*;

    logic        start;
    logic [15:0] seed;
    logic [7:0]  safe_addr;
    logic [7:0]  read_addr;
    logic [7:0]  write_addr;
    cell_t       din;
    logic        we;
    cell_t       dout;
    cell_t       dTL, dT, dTR, dL, dR, dBL, dB, dBR;
    logic        busy;
    logic        done;

    modport master (
        input  start, seed, safe_addr, dout,
        input  dTL, dT, dTR, dL, dR, dBL, dB, dBR,
        output read_addr, write_addr, din, we, busy, done
    );

    modport slave (
        output start, seed, safe_addr, dout,
        output dTL, dT, dTR, dL, dR, dBL, dB, dBR,
        input  read_addr, write_addr, din, we, busy, done
    );

endinterface

// File: rtl/minesweeper_adj_count.sv
// Edge-masked popcount of the eight neighbour mine bits;
// wrapped RAM neighbours on the board border are dropped.
module minesweeper_adj_count
    import minesweeper_pkg::*;
(
    input  logic [7:0] addr,
    input  logic [7:0] nbr,
    output logic [3:0] cnt
);

    logic [3:0] row, col;
    logic       top, bot, lft, rgt;
    logic [7:0] mask;

    assign row  = addr[7:4];
    assign col  = addr[3:0];
    assign top  = (row != 4'd0);
    assign bot  = (row != 4'(BOARD_DIM - 1));
    assign lft  = (col != 4'd0);
    assign rgt  = (col != 4'(BOARD_DIM - 1));
    // order: TL, T, TR, L, R, BL, B, BR
    assign mask = {top & lft, top, top & rgt, lft,
                   rgt, bot & lft, bot, bot & rgt};

    // count neighbours that are both mined and on the board
    always_comb begin
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, nbr[i] & mask[i]};
        end
    end

endmodule

// File: rtl/minesweeper_board_gen.sv
// Board generator: clears the RAM, scatters mines from an
// LFSR away from the first click, then writes neighbour counts.
module minesweeper_board_gen
    import minesweeper_pkg::*;
#(
    parameter int          NUM_MINES  = 40,
    parameter logic [15:0] LFSR_DEFSD = 16'hACE1
) (
    input logic clk,
    input logic reset,
    minesweeper_board_gen_if.master bus
);

    localparam logic [7:0] MINES = 8'(NUM_MINES);

    logic [2:0]  state;
    logic [15:0] lfsr, lfsr_nx;
    logic [7:0]  safe, placed, rd_q, cand;
    logic [8:0]  cidx;
    logic        fwd;
    logic [7:0]  nbr;
    logic [3:0]  cnt;

    assign cand    = lfsr[7:0];
    assign lfsr_nx = lfsr_step(lfsr);
    assign nbr     = {bus.dTL[CELL_MINE], bus.dT[CELL_MINE],
                      bus.dTR[CELL_MINE], bus.dL[CELL_MINE],
                      bus.dR[CELL_MINE],  bus.dBL[CELL_MINE],
                      bus.dB[CELL_MINE],  bus.dBR[CELL_MINE]};

    minesweeper_adj_count u_adj (
        .addr (rd_q),
        .nbr  (nbr),
        .cnt  (cnt)
    );

    // main sequencer; outputs are set on entry to the state using them
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= S_IDLE;
            bus.read_addr  <= 8'd0;
            bus.write_addr <= 8'd0;
            bus.din        <= '0;
            bus.we         <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            lfsr           <= LFSR_DEFSD;
            safe           <= 8'd0;
            placed         <= 8'd0;
            rd_q           <= 8'd0;
            cidx           <= 9'd0;
            fwd            <= 1'b0;
        end else begin
            rd_q     <= bus.read_addr;
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        lfsr <= (bus.seed == 16'h0) ? LFSR_DEFSD
                                                    : bus.seed;
                        safe           <= bus.safe_addr;
                        placed         <= 8'd0;
                        bus.busy       <= 1'b1;
                        bus.we         <= 1'b1;
                        bus.write_addr <= 8'd0;
                        bus.din        <= '0;
                        state          <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (bus.write_addr == 8'hFF) begin
                        bus.we        <= 1'b0;
                        lfsr          <= lfsr_nx;
                        bus.read_addr <= lfsr_nx[7:0];
                        state         <= S_PLACE_RD;
                    end else begin
                        bus.write_addr <= bus.write_addr + 8'd1;
                    end
                end
                S_PLACE_RD: begin
                    // a mine written this cycle is not yet in dout
                    bus.we <= 1'b0;
                    if (placed == MINES) begin
                        bus.read_addr <= 8'd0;
                        cidx          <= 9'd0;
                        state         <= S_COUNT;
                    end else begin
                        fwd   <= bus.we && (bus.write_addr == cand);
                        state <= S_PLACE_CHK;
                    end
                end
                S_PLACE_CHK: begin
                    if (!bus.dout[CELL_MINE] && !fwd && cand != safe) begin
                        bus.we         <= 1'b1;
                        bus.write_addr <= cand;
                        bus.din        <= make_cell(1'b1, 4'd0);
                        placed         <= placed + 8'd1;
                    end
                    lfsr          <= lfsr_nx;
                    bus.read_addr <= lfsr_nx[7:0];
                    state         <= S_PLACE_RD;
                end
                S_COUNT: begin
                    cidx          <= cidx + 9'd1;
                    bus.read_addr <= cidx[7:0] + 8'd1;
                    if (cidx != 9'd0) begin
                        bus.we         <= 1'b1;
                        bus.write_addr <= rd_q;
                        bus.din        <= make_cell(bus.dout[CELL_MINE], cnt);
                    end
                    if (cidx == 9'd256) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    bus.we   <= 1'b0;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_minesweeper_board_gen.sv
// Scoreboard bench for minesweeper_board_gen with a
// behavioural board RAM (1-cycle read, 8 neighbour ports).
module tb_minesweeper_board_gen;
    import minesweeper_pkg::*;

    localparam int NM      = 40;
    localparam int K_CNT   = 0;
    localparam int K_MINE  = 1;
    localparam int K_NMINE = 2;
    localparam int K_BAD   = 3;
    localparam int K_DUR   = 4;

    typedef struct {
        int kind;
        int addr;
        int val;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    minesweeper_board_gen_if bus ();

    minesweeper_board_gen #(
        .NUM_MINES  (NM),
        .LFSR_DEFSD (16'hACE1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    cell_t mem [256];
    logic  forced [256];
    logic  hook = 1'b0;

    exp_t q [$];
    exp_t e;
    int   passed  = 0;
    int   total   = 0;
    int   cyc     = 0;
    int   n_place = 0;
    int   t_mine  = 0;
    int   t_last  = 0;
    int   ndone   = 0;
    logic busy_q  = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // in hook mode the mine bit comes only from the forced map
    function automatic cell_t eff(input logic [7:0] a);
        cell_t c;
        c = mem[a];
        if (hook) c[CELL_MINE] = forced[a];
        return c;
    endfunction

    function automatic int ref_cnt(input int a);
        int r, c, n;
        r = a / 16;
        c = a % 16;
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 16 &&
                    c + dc >= 0 && c + dc < 16)
                    n += int'(mem[(r + dr) * 16 + c + dc][CELL_MINE]);
        return n;
    endfunction

    task automatic score(input exp_t x);
        int    act;
        string nm;
        act = 0;
        nm  = "";
        case (x.kind)
            K_CNT: begin
                act = int'(mem[x.addr][3:6]);
                nm  = $sformatf("cnt[%0d]", x.addr);
            end
            K_MINE: begin
                act = int'(mem[x.addr][CELL_MINE]);
                nm  = $sformatf("mine[%0d]", x.addr);
            end
            K_NMINE: begin
                for (int a = 0; a < 256; a++)
                    act += int'(mem[a][CELL_MINE]);
                nm = "mine_total";
            end
            K_BAD: begin
                for (int a = 0; a < 256; a++)
                    if (int'(mem[a][3:6]) != ref_cnt(a)) act++;
                nm = "bad_counts";
            end
            default: begin
                act = t_last - t_mine - 1;
                nm  = "count_cycles";
            end
        endcase
        check(nm, act, x.val);
    endtask

    task automatic push(input int k, input int a, input int v);
        exp_t x;
        x.kind = k;
        x.addr = a;
        x.val  = v;
        q.push_back(x);
    endtask

    task automatic clr_forced();
        for (int i = 0; i < 256; i++) forced[i] = 1'b0;
    endtask

    task automatic run(input logic [15:0] sd, input logic [7:0] sa,
                       input bit hold);
        int d0;
        bit seen;
        d0   = ndone;
        seen = 1'b0;
        @(negedge clk);
        bus.seed      = sd;
        bus.safe_addr = sa;
        bus.start     = 1'b1;
        if (!hold) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        bus.start = 1'b0;
        check("run_done", int'(seen), 1);
        repeat (10) @(negedge clk);
        check("done_once", ndone - d0, 1);
        check("busy_idle", int'(bus.busy), 0);
    endtask

    // board RAM: read-before-write, neighbour addresses wrap mod 256
    always @(posedge clk) begin
        if (bus.we) mem[bus.write_addr] <= bus.din;
        bus.dout <= eff(bus.read_addr);
        bus.dTL  <= eff(bus.read_addr - 8'd17);
        bus.dT   <= eff(bus.read_addr - 8'd16);
        bus.dTR  <= eff(bus.read_addr - 8'd15);
        bus.dL   <= eff(bus.read_addr - 8'd1);
        bus.dR   <= eff(bus.read_addr + 8'd1);
        bus.dBL  <= eff(bus.read_addr + 8'd15);
        bus.dB   <= eff(bus.read_addr + 8'd16);
        bus.dBR  <= eff(bus.read_addr + 8'd17);
    end

    // monitor: phase timing and scoreboard drain on every done pulse
    always @(negedge clk) begin
        cyc++;
        if (bus.busy && !busy_q) begin
            n_place = 0;
            t_mine  = 0;
            t_last  = 0;
        end
        busy_q = bus.busy;
        if (bus.we && n_place == NM && bus.write_addr == 8'hFF) begin
            t_last = cyc;
        end else if (bus.we && bus.din == 7'b1000000 && n_place < NM) begin
            n_place++;
            if (n_place == NM) t_mine = cyc;
        end
        if (bus.done) begin
            ndone++;
            while (q.size() > 0) begin
                e = q.pop_front();
                score(e);
            end
        end
    end

    initial begin
        bus.start     = 1'b0;
        bus.seed      = 16'h0;
        bus.safe_addr = 8'h0;
        for (int i = 0; i < 256; i++) mem[i] = 7'h7F;
        clr_forced();

        repeat (3) @(negedge clk);
        check("rst_read_addr", int'(bus.read_addr), 0);
        check("rst_write_addr", int'(bus.write_addr), 0);
        check("rst_din", int'(bus.din), 0);
        check("rst_we", int'(bus.we), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        reset = 1'b1;

        // random board from the default seed
        push(K_NMINE, 0, NM);
        push(K_MINE, 8'h37, 0);
        push(K_BAD, 0, 0);
        push(K_DUR, 0, 257);
        run(16'h0000, 8'h37, 1'b0);

        // lone mine in the corner: no wrap-around counts
        hook = 1'b1;
        clr_forced();
        forced[0] = 1'b1;
        push(K_MINE, 0, 1);
        push(K_CNT, 0, 0);
        push(K_CNT, 1, 1);
        push(K_CNT, 16, 1);
        push(K_CNT, 17, 1);
        push(K_CNT, 15, 0);
        push(K_CNT, 240, 0);
        push(K_CNT, 255, 0);
        run(16'hBEEF, 8'h80, 1'b0);

        // mines at 15 and 16 sit across the row wrap
        clr_forced();
        forced[15] = 1'b1;
        forced[16] = 1'b1;
        push(K_CNT, 0, 1);
        push(K_CNT, 31, 1);
        push(K_CNT, 14, 1);
        push(K_CNT, 1, 1);
        push(K_CNT, 15, 0);
        push(K_CNT, 16, 0);
        run(16'h0F0F, 8'h80, 1'b0);

        // fully surrounded cell 0x55
        clr_forced();
        forced[8'h44] = 1'b1;
        forced[8'h45] = 1'b1;
        forced[8'h46] = 1'b1;
        forced[8'h54] = 1'b1;
        forced[8'h56] = 1'b1;
        forced[8'h64] = 1'b1;
        forced[8'h65] = 1'b1;
        forced[8'h66] = 1'b1;
        push(K_CNT, 8'h55, 8);
        push(K_MINE, 8'h55, 0);
        push(K_CNT, 8'h44, 2);
        run(16'h3C3C, 8'h00, 1'b0);

        // reset in the middle of the count pass, then a clean rerun
        hook = 1'b0;
        @(negedge clk);
        bus.seed      = 16'h1234;
        bus.safe_addr = 8'h10;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3000 && n_place < NM; i++) @(negedge clk);
        check("reach_count", n_place, NM);
        repeat (20) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_we", int'(bus.we), 0);
        check("midrst_busy", int'(bus.busy), 0);
        @(negedge clk);
        reset = 1'b1;
        push(K_NMINE, 0, NM);
        push(K_MINE, 8'h10, 0);
        push(K_BAD, 0, 0);
        push(K_DUR, 0, 257);
        run(16'h1234, 8'h10, 1'b0);

        // start held high for the whole run
        push(K_DUR, 0, 257);
        push(K_NMINE, 0, NM);
        push(K_BAD, 0, 0);
        run(16'h5A5A, 8'hC3, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
